hazard_sb: RTL and testbench

//  Parametrised hazard/stall controller for the 5-stage MIPS core (F/D/E/M/W).

---
 rtl/hazard_sb.sv | 154 +++++++++++++++
 tb/tb_hazard_sb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_sb : 5-stage hazard/stall controller with N-deep forwarding,      |
// |             multi-cycle op scoreboard and pending-flush FSM. Rev 1.0      |
// +--------------------------------------------------------------------------+
module hazard_sb #(
  parameter int RAW      = 5,
  parameter int NFWD     = 2,
  parameter int MAX_PEND = 4,
  parameter int FSW      = $clog2(NFWD + 1),
  parameter int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               d_stall,
  input  logic [RAW-1:0]     rsD,
  input  logic [RAW-1:0]     rtD,
  input  logic [RAW-1:0]     wregD,
  input  logic [RAW-1:0]     rsE,
  input  logic [RAW-1:0]     rtE,
  input  logic [RAW-1:0]     wregE,
  input  logic               memtoregE,
  input  logic               long_issueE,
  input  logic               long_done,
  input  logic [RAW-1:0]     long_wreg,
  input  logic [NFWD*RAW-1:0] fwd_wreg,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic               judgeM,
  input  logic               excM,
  output logic [FSW-1:0]     forwardAE,
  output logic [FSW-1:0]     forwardBE,
  output logic               forwardAD,
  output logic               forwardBD,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               stallW,
  output logic               flushD,
  output logic               flushE,
  output logic               flushM,
  output logic               flushW,
  output logic               all_stall,
  output logic               long_kill,
  output logic [PW-1:0]      pend_cnt
);

  localparam logic [PW-1:0] c_max_pend = PW'(MAX_PEND);

  typedef enum logic [1:0] {IDLE = 2'd0, BR_PEND = 2'd1, EX_PEND = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [2**RAW-1:0]      sb_q, sb_d;
  logic [PW-1:0]          pend_cnt_q, pend_cnt_d;

  logic load_use, sb_hit, fullE, hz, br_req, exc_req, ok, accept, done_ok;

  // Scan from the farthest stage down so the nearest (youngest) producer wins.
  always_comb begin
    forwardAE = '0;
    forwardBE = '0;
    for (int k = NFWD; k >= 1; k--) begin
      if (fwd_we[k-1] && fwd_wreg[k*RAW-1 -: RAW] == rsE && rsE != '0)
        forwardAE = FSW'(k);
      if (fwd_we[k-1] && fwd_wreg[k*RAW-1 -: RAW] == rtE && rtE != '0)
        forwardBE = FSW'(k);
    end
  end

  assign forwardAD = fwd_we[0] && fwd_wreg[RAW-1:0] == rsD && rsD != '0;
  assign forwardBD = fwd_we[0] && fwd_wreg[RAW-1:0] == rtD && rtD != '0;

  assign all_stall = i_stall | d_stall;
  assign ok        = ~all_stall;
  assign load_use  = memtoregE && wregE != '0 && (wregE == rsD || wregE == rtD);
  assign sb_hit    = sb_q[rsD] | sb_q[rtD] | sb_q[wregD];
  assign fullE     = long_issueE && pend_cnt_q == c_max_pend;
  assign hz        = load_use | sb_hit | fullE;

  assign br_req  = judgeM | (state_q == BR_PEND);
  assign exc_req = excM | (state_q == EX_PEND);

  assign stallF = (all_stall | hz) & ~exc_req;
  assign stallD = all_stall | hz;
  assign stallE = all_stall | fullE;
  assign stallM = all_stall;
  assign stallW = all_stall;
  assign flushD = (br_req | exc_req) & ok;
  assign flushE = (br_req | exc_req | (hz & ~fullE)) & ok;
  assign flushM = (exc_req | fullE) & ok;
  assign flushW = exc_req & ok;

  assign long_kill = exc_req & ok;
  assign accept    = long_issueE & ~stallE & ~exc_req;
  assign done_ok   = long_done && pend_cnt_q != '0;
  assign pend_cnt  = pend_cnt_q;

  // Clear before set so a same-register set/clear pair leaves the bit set.
  always_comb begin
    sb_d       = sb_q;
    pend_cnt_d = pend_cnt_q;
    if (long_kill) begin
      sb_d       = '0;
      pend_cnt_d = '0;
    end else begin
      if (done_ok)
        sb_d[long_wreg] = 1'b0;
      if (accept && wregE != '0)
        sb_d[wregE] = 1'b1;
      if (accept && !done_ok)
        pend_cnt_d = pend_cnt_q + 1'b1;
      else if (!accept && done_ok)
        pend_cnt_d = pend_cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (excM && all_stall)
          state_d = EX_PEND;
        else if (judgeM && all_stall)
          state_d = BR_PEND;
      end
      BR_PEND: begin
        if (excM)
          state_d = EX_PEND;
        else if (!all_stall)
          state_d = IDLE;
      end
      EX_PEND: begin
        if (!all_stall)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sb_q       <= '0;
      pend_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_sb : directed self-checking bench for hazard_sb. Rev 1.0        |
// +--------------------------------------------------------------------------+
module tb_hazard_sb;
  logic       clk, rst, i_stall, d_stall;
  logic [4:0] rsD, rtD, wregD, rsE, rtE, wregE, long_wreg;
  logic       memtoregE, long_issueE, long_done, judgeM, excM;
  logic [9:0] fwd_wreg;
  logic [1:0] fwd_we, forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW, all_stall, long_kill;
  logic [2:0] pend_cnt;
  int         tests, fails;

  wire [4:0] stalls  = {stallF, stallD, stallE, stallM, stallW};
  wire [3:0] flushes = {flushD, flushE, flushM, flushW};

  hazard_sb dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
    .rsD(rsD), .rtD(rtD), .wregD(wregD), .rsE(rsE), .rtE(rtE), .wregE(wregE),
    .memtoregE(memtoregE), .long_issueE(long_issueE), .long_done(long_done),
    .long_wreg(long_wreg), .fwd_wreg(fwd_wreg), .fwd_we(fwd_we),
    .judgeM(judgeM), .excM(excM), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM), .stallW(stallW), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .flushW(flushW), .all_stall(all_stall),
    .long_kill(long_kill), .pend_cnt(pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    i_stall = 0; d_stall = 0; rsD = 0; rtD = 0; wregD = 0; rsE = 0; rtE = 0;
    wregE = 0; memtoregE = 0; long_issueE = 0; long_done = 0; long_wreg = 0;
    fwd_wreg = 0; fwd_we = 0; judgeM = 0; excM = 0;
  endtask

  task automatic test_reset;
    clr();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests++;
    if (stalls !== 5'b0) begin fails++; $display("FAIL reset_stalls: got %b expected 00000", stalls); end
    tests++;
    if (flushes !== 4'b0) begin fails++; $display("FAIL reset_flushes: got %b expected 0000", flushes); end
    tests++;
    if ({forwardAE, forwardBE, forwardAD, forwardBD, all_stall, long_kill, pend_cnt} !== 11'b0) begin
      fails++; $display("FAIL reset_misc: got %b expected 0", {forwardAE, forwardBE, forwardAD, forwardBD, all_stall, long_kill, pend_cnt});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward;
    clr();
    fwd_we = 2'b11; fwd_wreg = {5'd5, 5'd5}; rsE = 5; rsD = 5;
    #1;
    tests++;
    if ({forwardAE, forwardAD} !== 3'b011) begin fails++; $display("FAIL fwd_both_stages: got AE=%0d AD=%0d expected AE=1 AD=1", forwardAE, forwardAD); end
    fwd_we = 2'b10; rtE = 5; rtD = 5;
    #1;
    tests++;
    if ({forwardAE, forwardBE, forwardAD, forwardBD} !== 6'b101000) begin
      fails++; $display("FAIL fwd_stage2_only: got AE=%0d BE=%0d AD=%0d BD=%0d expected 2 2 0 0", forwardAE, forwardBE, forwardAD, forwardBD);
    end
    fwd_we = 2'b11; fwd_wreg = {5'd6, 5'd5}; rsE = 6; rtE = 5;
    #1;
    tests++;
    if ({forwardAE, forwardBE} !== 4'b1001) begin fails++; $display("FAIL fwd_split: got AE=%0d BE=%0d expected 2 1", forwardAE, forwardBE); end
    fwd_wreg = 10'b0; rsE = 0; rtE = 0; rsD = 0;
    #1;
    tests++;
    if ({forwardAE, forwardBE, forwardAD} !== 5'b0) begin fails++; $display("FAIL fwd_r0: got AE=%0d BE=%0d AD=%0d expected 0", forwardAE, forwardBE, forwardAD); end
  endtask

  task automatic test_load_use;
    clr();
    memtoregE = 1; wregE = 8; rtD = 8;
    #1;
    tests++;
    if ({stalls, flushes} !== 9'b11000_0100) begin fails++; $display("FAIL load_use_hit: got stalls=%b flushes=%b expected 11000 0100", stalls, flushes); end
    tick();
    memtoregE = 0; wregE = 0;
    #1;
    tests++;
    if ({stalls, flushes} !== 9'b0) begin fails++; $display("FAIL load_use_after: got stalls=%b flushes=%b expected 0", stalls, flushes); end
    memtoregE = 1; rtD = 0;
    #1;
    tests++;
    if (stallD !== 1'b0) begin fails++; $display("FAIL load_use_r0: got %b expected 0", stallD); end
  endtask

  task automatic test_scoreboard;
    clr();
    long_issueE = 1; wregE = 9;
    tick();
    long_issueE = 0; wregE = 0; rsD = 9;
    #1;
    tests++;
    if ({pend_cnt, stallD, flushE} !== 5'b001_1_1) begin fails++; $display("FAIL sb_raw_stall: got pend=%0d stallD=%b flushE=%b expected 1 1 1", pend_cnt, stallD, flushE); end
    tick();
    long_done = 1; long_wreg = 9;
    #1;
    tests++;
    if (stallD !== 1'b1) begin fails++; $display("FAIL sb_done_cycle: got stallD=%b expected 1", stallD); end
    tick();
    long_done = 0;
    #1;
    tests++;
    if ({pend_cnt, stallD} !== 4'b000_0) begin fails++; $display("FAIL sb_released: got pend=%0d stallD=%b expected 0 0", pend_cnt, stallD); end
    long_done = 1; long_wreg = 3;
    tick();
    long_done = 0;
    #1;
    tests++;
    if (pend_cnt !== 3'd0) begin fails++; $display("FAIL sb_done_at_zero: got pend=%0d expected 0", pend_cnt); end
  endtask

  task automatic test_back_to_back;
    clr();
    long_issueE = 1; wregE = 9;
    tick();
    long_done = 1; long_wreg = 9;
    tick();
    long_issueE = 0; long_done = 0; wregE = 0; wregD = 9;
    #1;
    tests++;
    if ({pend_cnt, stallD} !== 4'b001_1) begin fails++; $display("FAIL b2b_set_wins: got pend=%0d stallD=%b expected 1 1", pend_cnt, stallD); end
    long_done = 1; long_wreg = 9;
    tick();
    long_done = 0;
    #1;
    tests++;
    if ({pend_cnt, stallD} !== 4'b000_0) begin fails++; $display("FAIL b2b_drain: got pend=%0d stallD=%b expected 0 0", pend_cnt, stallD); end
  endtask

  task automatic test_full;
    clr();
    long_issueE = 1;
    for (int i = 0; i < 4; i++) begin
      wregE = 5'(10 + i);
      tick();
    end
    wregE = 14;
    #1;
    tests++;
    if ({pend_cnt, stalls, flushes} !== 12'b100_11100_0010) begin
      fails++; $display("FAIL full_stall: got pend=%0d stalls=%b flushes=%b expected 4 11100 0010", pend_cnt, stalls, flushes);
    end
    tick();
    long_done = 1; long_wreg = 10;
    #1;
    tests++;
    if ({pend_cnt, stallE} !== 4'b100_1) begin fails++; $display("FAIL full_hold: got pend=%0d stallE=%b expected 4 1", pend_cnt, stallE); end
    tick();
    long_done = 0;
    #1;
    tests++;
    if ({pend_cnt, stallE} !== 4'b011_0) begin fails++; $display("FAIL full_release: got pend=%0d stallE=%b expected 3 0", pend_cnt, stallE); end
    tick();
    long_issueE = 0; wregE = 0;
    #1;
    tests++;
    if (pend_cnt !== 3'd4) begin fails++; $display("FAIL full_refill: got pend=%0d expected 4", pend_cnt); end
    excM = 1;
    tick();
    excM = 0;
    #1;
    tests++;
    if (pend_cnt !== 3'd0) begin fails++; $display("FAIL full_kill: got pend=%0d expected 0", pend_cnt); end
  endtask

  task automatic test_pending_branch;
    clr();
    judgeM = 1; d_stall = 1;
    #1;
    tests++;
    if ({flushes, stalls, all_stall} !== 10'b0000_11111_1) begin
      fails++; $display("FAIL br_stalled: got flushes=%b stalls=%b all=%b expected 0000 11111 1", flushes, stalls, all_stall);
    end
    tick();
    judgeM = 0;
    #1;
    tests++;
    if (flushes !== 4'b0) begin fails++; $display("FAIL br_held1: got %b expected 0000", flushes); end
    tick();
    tests++;
    if (flushes !== 4'b0) begin fails++; $display("FAIL br_held2: got %b expected 0000", flushes); end
    d_stall = 0;
    #1;
    tests++;
    if (flushes !== 4'b1100) begin fails++; $display("FAIL br_apply: got %b expected 1100", flushes); end
    tick();
    tests++;
    if (flushes !== 4'b0) begin fails++; $display("FAIL br_idle: got %b expected 0000", flushes); end
  endtask

  task automatic test_pending_exc;
    clr();
    excM = 1; i_stall = 1;
    #1;
    tests++;
    if ({flushes, long_kill, stallF} !== 6'b0) begin fails++; $display("FAIL exc_stalled: got flushes=%b kill=%b stallF=%b expected 0", flushes, long_kill, stallF); end
    tick();
    excM = 0;
    #1;
    tests++;
    if (flushes !== 4'b0) begin fails++; $display("FAIL exc_held: got %b expected 0000", flushes); end
    i_stall = 0;
    #1;
    tests++;
    if ({flushes, long_kill} !== 5'b1111_1) begin fails++; $display("FAIL exc_apply: got flushes=%b kill=%b expected 1111 1", flushes, long_kill); end
    tick();
    tests++;
    if ({flushes, long_kill} !== 5'b0) begin fails++; $display("FAIL exc_idle: got flushes=%b kill=%b expected 0", flushes, long_kill); end
  endtask

  task automatic test_exception;
    clr();
    long_issueE = 1; wregE = 9;
    tick();
    wregE = 4;
    tick();
    long_issueE = 0; wregE = 0; excM = 1; long_done = 1; long_wreg = 4;
    #1;
    tests++;
    if ({pend_cnt, flushes, long_kill} !== 8'b010_1111_1) begin
      fails++; $display("FAIL exc_kill: got pend=%0d flushes=%b kill=%b expected 2 1111 1", pend_cnt, flushes, long_kill);
    end
    tick();
    excM = 0; long_done = 0; rsD = 9;
    #1;
    tests++;
    if ({pend_cnt, stallD} !== 4'b0) begin fails++; $display("FAIL exc_cleared: got pend=%0d stallD=%b expected 0 0", pend_cnt, stallD); end
  endtask

  task automatic test_async_reset;
    clr();
    long_issueE = 1; wregE = 7;
    tick();
    long_issueE = 0; wregE = 0; rsD = 7;
    #1;
    tests++;
    if (stallD !== 1'b1) begin fails++; $display("FAIL arst_pre: got stallD=%b expected 1", stallD); end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({pend_cnt, stallD} !== 4'b0) begin fails++; $display("FAIL arst_now: got pend=%0d stallD=%b expected 0 0", pend_cnt, stallD); end
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_back_to_back();
    test_full();
    test_pending_branch();
    test_pending_exc();
    test_exception();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
